mem_tile_arbiter: RTL and testbench
===================================

Name: mem_tile_arbiter

Overview:
- Two-port arbiter that shares one memory port between the instruction-cache tile and the data-cache tile.
- Both requesters speak the same cache-to-memory protocol: 32-bit address, 128-bit data, OE/WR strobes, 5-bit op, 2-bit OK.
- A grant is held for a requester's whole multi-beat tile transfer (fill or writeback) and released only when that requester idles.
- Sits between the cache tiles and the external memory/bus interface.

Parameters:
- IDLE_GAP, 1, dead cycles with no grant between release and the next arbitration (1..3).
- OK_READY, 2'b00, memory OK code: idle/ready.
- OK_OK, 2'b01, memory OK code: beat complete.
- OK_HOLD, 2'b10, memory OK code: busy/wait.
- OK_FAULT, 2'b11, memory OK code: access fault.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- icAddr  in  32  I-tile memory address.
- icOE  in  1  I-tile load strobe.
- icWR  in  1  I-tile store strobe (normally 0).
- icOp  in  5  I-tile memory op.
- icOutData  in  128  I-tile store data.
- icData  out  128  read data to I-tile.
- icOK  out  2  status to I-tile.
- dcAddr  in  32  D-tile memory address.
- dcOE  in  1  D-tile load strobe.
- dcWR  in  1  D-tile store strobe.
- dcOp  in  5  D-tile memory op.
- dcOutData  in  128  D-tile store data.
- dcData  out  128  read data to D-tile.
- dcOK  out  2  status to D-tile.
- memAddr  out  32  memory address.
- memOE  out  1  memory load strobe.
- memWR  out  1  memory store strobe.
- memOp  out  5  memory op.
- memOutData  out  128  memory store data.
- memData  in  128  memory read data.
- memOK  in  2  memory status.

Behaviour:
- Request definitions: reqI = icOE|icWR; reqD = dcOE|dcWR.
- FSM state register: IDLE(0), GNT_I(1), GNT_D(2), DRAIN(3), GAP(4).
- Reset: state=IDLE, gap counter=0, lastGnt=D (so the I-tile wins the first tie when round robin is enabled).
- Reset output values, held for as long as reset is high: memAddr=0, memOE=0, memWR=0, memOp=0, memOutData=0, icOK=dcOK=OK_READY, icData=dcData=0.
- IDLE:
  - Arbitrate on reqI/reqD as sampled this cycle.
  - The D-tile wins a simultaneous request (fixed priority, see Optional Feature).
  - Transition to GNT_x takes effect next cycle, so first-request-to-memOE latency is exactly 1 cycle.
- GNT_x:
  - Owner's addr/OE/WR/op/data pass combinationally to mem*.
  - memData and memOK pass combinationally to the owner's data/OK outputs.
  - Non-owner: OK=OK_HOLD if it is requesting, else OK_READY; its data output = 0.
  - When the owner drops both OE and WR: memOE=memWR=0 that cycle; if memOK==OK_READY go to GAP, otherwise go to DRAIN.
  - An owner re-asserting a strobe in the same cycle memOK returns OK_OK stays granted. Back-to-back beats (DWORD bursts, RMW) never lose the grant.
- DRAIN:
  - mem strobes = 0; both requesters see OK_HOLD (or OK_READY if not requesting).
  - Go to GAP on memOK==OK_READY.
- GAP:
  - mem strobes = 0; count IDLE_GAP cycles, then go to IDLE.
  - Non-owner keeps seeing OK_HOLD while requesting.
- Fault: OK_FAULT from memory is forwarded to the owner unchanged. The grant is kept until the owner idles; the arbiter never aborts a transfer.
- Update lastGnt on every IDLE->GNT transition.
- Reset mid-transfer: immediate return to IDLE with reset output values; no cleanup beat is issued.
- Deassertion of a non-owner's request while it waits has no effect on state.

Optional Feature:
- Macro: MEMARB_ROUNDROBIN_EN.
- Defined: simultaneous requests in IDLE go to the requester that is not lastGnt. Alternation is guaranteed under constant contention.
- Undefined: fixed priority, D-tile always wins ties. lastGnt is still maintained but ignored.
- Single-requester behaviour is identical either way.

Test Plan:
- Reset held 3 cycles with dcOE=1 -> memOE=0 and dcOK=OK_READY throughout; memOE=1, memAddr=dcAddr on the 2nd cycle after reset falls.
- icOE=1 alone, icAddr=0x00001230, memOK=OK_OK after 2 cycles -> memAddr=0x00001230 from cycle+1; icOK=OK_OK and icData=memData in the same cycle memOK=OK_OK.
- D-tile 4-beat DWORD fill (addr 0x4000..0x400C) with icOE=1 raised at beat 2 -> all 4 beats issued to memory without a gap; icOK=OK_HOLD until dcOE drops; I-tile granted IDLE_GAP+1 cycles after memOK returns OK_READY.
- icOE and dcWR both raised the same cycle, twice in succession, macro undefined -> D granted both times; macro defined -> D then I.
- Owner drops OE while memOK=OK_HOLD for 3 cycles -> FSM stays in DRAIN 3 cycles with mem strobes 0; next grant only after OK_READY.
- memOK=OK_FAULT during a D-tile store -> dcOK=OK_FAULT that cycle; grant retained until dcWR=0; I-tile sees OK_HOLD meanwhile.

Source files
------------

// File: rtl/mem_tile_arbiter.sv
// mem_tile_arbiter: shares one memory port between the I-cache tile and the
// D-cache tile. A grant covers the owner's whole multi-beat tile transfer and
// is released only once the owner drops both strobes; the port then drains
// any outstanding memory activity and idles for IDLE_GAP cycles before the
// next arbitration.
//
// Configuration macro: MEMARB_ROUNDROBIN_EN
//   defined   - simultaneous requests go to the tile that was not granted last
//   undefined - fixed priority, the D-tile wins every tie
//
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   icAddr/icOE/icWR/icOp/icOutData  I-tile request;  icData/icOK  I-tile response
//   dcAddr/dcOE/dcWR/dcOp/dcOutData  D-tile request;  dcData/dcOK  D-tile response
//   memAddr/memOE/memWR/memOp/memOutData  shared memory request
//   memData/memOK                memory response
module mem_tile_arbiter #(
  parameter int unsigned IDLE_GAP = 1,
  parameter logic [1:0]  OK_READY = 2'b00,
  parameter logic [1:0]  OK_OK    = 2'b01,
  parameter logic [1:0]  OK_HOLD  = 2'b10,
  parameter logic [1:0]  OK_FAULT = 2'b11
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  icAddr,
  input  logic         icOE,
  input  logic         icWR,
  input  logic [4:0]   icOp,
  input  logic [127:0] icOutData,
  output logic [127:0] icData,
  output logic [1:0]   icOK,
  input  logic [31:0]  dcAddr,
  input  logic         dcOE,
  input  logic         dcWR,
  input  logic [4:0]   dcOp,
  input  logic [127:0] dcOutData,
  output logic [127:0] dcData,
  output logic [1:0]   dcOK,
  output logic [31:0]  memAddr,
  output logic         memOE,
  output logic         memWR,
  output logic [4:0]   memOp,
  output logic [127:0] memOutData,
  input  logic [127:0] memData,
  input  logic [1:0]   memOK
);

  localparam int unsigned GapW = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GNT_I = 3'd1,
    GNT_D = 3'd2,
    DRAIN = 3'd3,
    GAP   = 3'd4
  } arbStateT;

  arbStateT        state, stateNext;
  logic [GapW-1:0] gapCnt, gapCntNext;
  logic            lastGntD, lastGntDNext;
  logic            reqI, reqD;
  logic            tieToD;
  logic            pickD;
  logic            memPending;

  assign reqI = icOE | icWR;
  assign reqD = dcOE | dcWR;

  // Any status other than ready means memory is still finishing a beat.
  assign memPending = memOK inside {OK_OK, OK_HOLD, OK_FAULT};

  // Tie-break rule for simultaneous requests in IDLE.
`ifdef MEMARB_ROUNDROBIN_EN
  assign tieToD = ~lastGntD;
`else
  assign tieToD = 1'b1;
`endif

  assign pickD = reqD & (~reqI | tieToD);

  // State register, gap counter and last-grant history.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      gapCnt   <= '0;
      lastGntD <= 1'b1;
    end else begin
      state    <= stateNext;
      gapCnt   <= gapCntNext;
      lastGntD <= lastGntDNext;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNext    = state;
    gapCntNext   = gapCnt;
    lastGntDNext = lastGntD;
    case (state)
      IDLE: begin
        if (reqI | reqD) begin
          stateNext    = pickD ? GNT_D : GNT_I;
          lastGntDNext = pickD;
        end
      end
      GNT_I: begin
        if (!reqI) begin
          stateNext  = memPending ? DRAIN : GAP;
          gapCntNext = '0;
        end
      end
      GNT_D: begin
        if (!reqD) begin
          stateNext  = memPending ? DRAIN : GAP;
          gapCntNext = '0;
        end
      end
      DRAIN: begin
        if (!memPending) begin
          stateNext  = GAP;
          gapCntNext = '0;
        end
      end
      GAP: begin
        if (gapCnt == GapW'(IDLE_GAP - 1)) begin
          stateNext  = IDLE;
          gapCntNext = '0;
        end else begin
          gapCntNext = gapCnt + GapW'(1);
        end
      end
      default: begin
        stateNext  = IDLE;
        gapCntNext = '0;
      end
    endcase
  end

  // Output steering: the owner is wired straight through to memory; waiting
  // tiles see HOLD, idle tiles see READY. Reset forces the quiet values.
  always_comb begin
    memAddr    = '0;
    memOE      = 1'b0;
    memWR      = 1'b0;
    memOp      = '0;
    memOutData = '0;
    icData     = '0;
    dcData     = '0;
    icOK       = reqI ? OK_HOLD : OK_READY;
    dcOK       = reqD ? OK_HOLD : OK_READY;
    if (reset) begin
      icOK = OK_READY;
      dcOK = OK_READY;
    end else begin
      case (state)
        GNT_I: begin
          memAddr    = icAddr;
          memOE      = icOE;
          memWR      = icWR;
          memOp      = icOp;
          memOutData = icOutData;
          icData     = memData;
          icOK       = memOK;
        end
        GNT_D: begin
          memAddr    = dcAddr;
          memOE      = dcOE;
          memWR      = dcWR;
          memOp      = dcOp;
          memOutData = dcOutData;
          dcData     = memData;
          dcOK       = memOK;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_tile_arbiter.sv
module tb_mem_tile_arbiter;

  localparam int G = 2;
  localparam logic [1:0] RDY = 2'b00;
  localparam logic [1:0] OKB = 2'b01;
  localparam logic [1:0] HLD = 2'b10;
  localparam logic [1:0] FLT = 2'b11;

  logic         clock, reset;
  logic [31:0]  icAddr, dcAddr, memAddr;
  logic         icOE, icWR, dcOE, dcWR, memOE, memWR;
  logic [4:0]   icOp, dcOp, memOp;
  logic [127:0] icOutData, dcOutData, memOutData, icData, dcData, memData;
  logic [1:0]   icOK, dcOK, memOK;

  int checks;
  int errors;
  bit modelLastD;

  mem_tile_arbiter #(.IDLE_GAP(G)) dut (
    .clock(clock), .reset(reset),
    .icAddr(icAddr), .icOE(icOE), .icWR(icWR), .icOp(icOp), .icOutData(icOutData),
    .icData(icData), .icOK(icOK),
    .dcAddr(dcAddr), .dcOE(dcOE), .dcWR(dcWR), .dcOp(dcOp), .dcOutData(dcOutData),
    .dcData(dcData), .dcOK(dcOK),
    .memAddr(memAddr), .memOE(memOE), .memWR(memWR), .memOp(memOp),
    .memOutData(memOutData), .memData(memData), .memOK(memOK)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Spec tie rule: round robin gives the tie to the tile not granted last.
  function automatic bit tieWinnerD(input bit lastD);
`ifdef MEMARB_ROUNDROBIN_EN
    return !lastD;
`else
    return 1'b1;
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    icOE = 0; icWR = 0; dcOE = 0; dcWR = 0; memOK = RDY;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset = 1; dcOE = 1; dcAddr = $urandom; dcOp = 5'($urandom); memOK = OKB; memData = rand128();
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (memOE !== 1'b0) begin errors++; $display("FAIL reset_memOE cyc%0d got %0h exp 0", i, memOE); end
      checks++; if (dcOK !== RDY) begin errors++; $display("FAIL reset_dcOK cyc%0d got %0h exp %0h", i, dcOK, RDY); end
      checks++; if (memAddr !== 32'h0) begin errors++; $display("FAIL reset_memAddr got %0h exp 0", memAddr); end
      checks++; if (dcData !== 128'h0) begin errors++; $display("FAIL reset_dcData got %0h exp 0", dcData); end
      tick();
    end
    reset = 0; memOK = HLD;
    #2;
    checks++; if (memOE !== 1'b0) begin errors++; $display("FAIL post_reset_cyc1_memOE got %0h exp 0", memOE); end
    tick(); #2;
    checks++; if (memOE !== 1'b1) begin errors++; $display("FAIL post_reset_cyc2_memOE got %0h exp 1", memOE); end
    checks++; if (memAddr !== dcAddr) begin errors++; $display("FAIL post_reset_memAddr got %0h exp %0h", memAddr, dcAddr); end
    checks++; if (dcOK !== HLD) begin errors++; $display("FAIL post_reset_dcOK got %0h exp %0h", dcOK, HLD); end
    modelLastD = 1;
    tick(); memOK = OKB; memData = rand128(); #2;
    checks++; if (dcData !== memData) begin errors++; $display("FAIL post_reset_dcData got %0h exp %0h", dcData, memData); end
    tick();
    idle_cycles(G + 3);
  endtask

  task automatic test_single_i();
    icOE = 1; icAddr = 32'h0000_1230; icOp = 5'($urandom); icOutData = rand128(); memOK = RDY;
    #2;
    checks++; if (memOE !== 1'b0) begin errors++; $display("FAIL single_idle_memOE got %0h exp 0", memOE); end
    tick(); memOK = HLD; #2;
    checks++; if (memOE !== 1'b1) begin errors++; $display("FAIL single_memOE got %0h exp 1", memOE); end
    checks++; if (memAddr !== 32'h0000_1230) begin errors++; $display("FAIL single_memAddr got %0h exp 1230", memAddr); end
    checks++; if (memOp !== icOp) begin errors++; $display("FAIL single_memOp got %0h exp %0h", memOp, icOp); end
    checks++; if (memOutData !== icOutData) begin errors++; $display("FAIL single_memOutData got %0h exp %0h", memOutData, icOutData); end
    checks++; if (icOK !== HLD) begin errors++; $display("FAIL single_icOK_hold got %0h exp %0h", icOK, HLD); end
    checks++; if (dcOK !== RDY) begin errors++; $display("FAIL single_dcOK got %0h exp %0h", dcOK, RDY); end
    tick(); #2;
    tick(); memOK = OKB; memData = rand128(); #2;
    checks++; if (icOK !== OKB) begin errors++; $display("FAIL single_icOK_ok got %0h exp %0h", icOK, OKB); end
    checks++; if (icData !== memData) begin errors++; $display("FAIL single_icData got %0h exp %0h", icData, memData); end
    checks++; if (dcData !== 128'h0) begin errors++; $display("FAIL single_dcData got %0h exp 0", dcData); end
    tick(); icOE = 0; memOK = RDY; #2;
    checks++; if (memOE !== 1'b0) begin errors++; $display("FAIL single_release_memOE got %0h exp 0", memOE); end
    modelLastD = 0;
    idle_cycles(G + 3);
  endtask

  task automatic test_dword_fill();
    int n;
    dcOE = 1; dcAddr = 32'h0000_4000; dcOp = 5'($urandom); icAddr = $urandom; memOK = RDY;
    #2;
    tick();
    modelLastD = 1;
    for (int b = 0; b < 4; b++) begin
      int lat;
      dcAddr = 32'h0000_4000 + 32'(4 * b);
      if (b == 1) icOE = 1;
      lat = $urandom_range(0, 2);
      for (int s = 0; s <= lat; s++) begin
        memOK = (s == lat) ? OKB : HLD; memData = rand128(); #2;
        checks++; if (memOE !== 1'b1) begin errors++; $display("FAIL fill_memOE beat%0d got %0h exp 1", b, memOE); end
        checks++; if (memAddr !== dcAddr) begin errors++; $display("FAIL fill_memAddr beat%0d got %0h exp %0h", b, memAddr, dcAddr); end
        checks++; if (icOK !== (icOE ? HLD : RDY)) begin errors++; $display("FAIL fill_icOK beat%0d got %0h exp %0h", b, icOK, icOE ? HLD : RDY); end
        if (s == lat) begin
          checks++; if (dcOK !== OKB) begin errors++; $display("FAIL fill_dcOK beat%0d got %0h exp %0h", b, dcOK, OKB); end
          checks++; if (dcData !== memData) begin errors++; $display("FAIL fill_dcData beat%0d got %0h exp %0h", b, dcData, memData); end
        end
        tick();
      end
    end
    dcOE = 0; memOK = RDY; #2;
    checks++; if (memOE !== 1'b0) begin errors++; $display("FAIL fill_release_memOE got %0h exp 0", memOE); end
    checks++; if (icOK !== HLD) begin errors++; $display("FAIL fill_release_icOK got %0h exp %0h", icOK, HLD); end
    n = 0;
    while (n < 40) begin
      tick(); #2;
      if (memOE === 1'b1) break;
      checks++; if (icOK !== HLD) begin errors++; $display("FAIL fill_wait_icOK got %0h exp %0h", icOK, HLD); end
      n++;
    end
    checks++; if (n !== G + 1) begin errors++; $display("FAIL fill_dead_cycles got %0d exp %0d", n, G + 1); end
    checks++; if (memAddr !== icAddr) begin errors++; $display("FAIL fill_next_owner_addr got %0h exp %0h", memAddr, icAddr); end
    modelLastD = 0;
    tick();
    idle_cycles(G + 3);
  endtask

  task automatic test_reset_mid();
    icOE = 1; icAddr = $urandom; memOK = RDY; memData = rand128();
    #2; tick(); memOK = HLD; #2;
    checks++; if (memOE !== 1'b1) begin errors++; $display("FAIL rmid_memOE got %0h exp 1", memOE); end
    tick(); reset = 1; #2;
    checks++; if (memOE !== 1'b0) begin errors++; $display("FAIL rmid_reset_memOE got %0h exp 0", memOE); end
    checks++; if (memAddr !== 32'h0) begin errors++; $display("FAIL rmid_reset_memAddr got %0h exp 0", memAddr); end
    checks++; if (icOK !== RDY) begin errors++; $display("FAIL rmid_reset_icOK got %0h exp %0h", icOK, RDY); end
    checks++; if (icData !== 128'h0) begin errors++; $display("FAIL rmid_reset_icData got %0h exp 0", icData); end
    tick(); reset = 0; modelLastD = 1; #2;
    checks++; if (memOE !== 1'b0) begin errors++; $display("FAIL rmid_idle_memOE got %0h exp 0", memOE); end
    tick(); #2;
    checks++; if (memOE !== 1'b1 || memAddr !== icAddr) begin errors++; $display("FAIL rmid_regrant got oe=%0h addr=%0h exp oe=1 addr=%0h", memOE, memAddr, icAddr); end
    modelLastD = 0;
    tick();
    idle_cycles(G + 3);
  endtask

  task automatic test_tie();
    for (int r = 0; r < 2; r++) begin
      bit expD;
      logic [31:0] a;
      a = $urandom;
      icAddr = {a[31:1], 1'b0}; dcAddr = {a[31:1], 1'b1};
      icOE = 1; dcWR = 1; memOK = RDY;
      expD = tieWinnerD(modelLastD);
      #2; tick(); memOK = OKB; memData = rand128(); #2;
      checks++; if (memAddr !== (expD ? dcAddr : icAddr)) begin errors++; $display("FAIL tie%0d_owner_addr got %0h exp %0h", r, memAddr, expD ? dcAddr : icAddr); end
      checks++; if ({memOE, memWR} !== (expD ? 2'b01 : 2'b10)) begin errors++; $display("FAIL tie%0d_strobes got %0h exp %0h", r, {memOE, memWR}, expD ? 2'b01 : 2'b10); end
      checks++; if ((expD ? icOK : dcOK) !== HLD) begin errors++; $display("FAIL tie%0d_loser_OK got %0h exp %0h", r, expD ? icOK : dcOK, HLD); end
      modelLastD = expD;
      tick(); icOE = 0; dcWR = 0; memOK = RDY; #2;
      checks++; if ({memOE, memWR} !== 2'b00) begin errors++; $display("FAIL tie%0d_release got %0h exp 0", r, {memOE, memWR}); end
      idle_cycles(G + 3);
    end
  endtask

  task automatic test_drain();
    for (int it = 0; it < 2; it++) begin
      int nHold;
      int k;
      nHold = (it == 0) ? 3 : $urandom_range(1, 4);
      dcOE = 1; dcAddr = $urandom; icAddr = $urandom; memOK = RDY;
      #2; tick(); memOK = OKB; #2;
      checks++; if (memOE !== 1'b1 || memAddr !== dcAddr) begin errors++; $display("FAIL drain%0d_grant got oe=%0h addr=%0h exp oe=1 addr=%0h", it, memOE, memAddr, dcAddr); end
      modelLastD = 1;
      tick(); dcOE = 0; icOE = 1;
      k = 0;
      while (k < 40) begin
        memOK = (k < nHold) ? HLD : RDY; #2;
        if (memOE === 1'b1) break;
        checks++; if (memWR !== 1'b0) begin errors++; $display("FAIL drain%0d_memWR k%0d got %0h exp 0", it, k, memWR); end
        checks++; if (icOK !== HLD) begin errors++; $display("FAIL drain%0d_icOK k%0d got %0h exp %0h", it, k, icOK, HLD); end
        tick();
        k++;
      end
      checks++; if (k !== nHold + G + 2) begin errors++; $display("FAIL drain%0d_dead_cycles hold=%0d got %0d exp %0d", it, nHold, k, nHold + G + 2); end
      checks++; if (memAddr !== icAddr) begin errors++; $display("FAIL drain%0d_next_addr got %0h exp %0h", it, memAddr, icAddr); end
      modelLastD = 0;
      tick();
      idle_cycles(G + 3);
    end
  endtask

  task automatic test_fault();
    int n;
    dcWR = 1; dcAddr = $urandom; dcOp = 5'($urandom); dcOutData = rand128(); icAddr = $urandom; memOK = RDY;
    #2; tick(); icOE = 1; memOK = HLD; #2;
    checks++; if ({memOE, memWR} !== 2'b01) begin errors++; $display("FAIL fault_strobes got %0h exp 1", {memOE, memWR}); end
    checks++; if (memOutData !== dcOutData) begin errors++; $display("FAIL fault_memOutData got %0h exp %0h", memOutData, dcOutData); end
    checks++; if (memOp !== dcOp) begin errors++; $display("FAIL fault_memOp got %0h exp %0h", memOp, dcOp); end
    modelLastD = 1;
    tick(); memOK = FLT; memData = rand128(); #2;
    checks++; if (dcOK !== FLT) begin errors++; $display("FAIL fault_dcOK got %0h exp %0h", dcOK, FLT); end
    checks++; if (icOK !== HLD) begin errors++; $display("FAIL fault_icOK got %0h exp %0h", icOK, HLD); end
    for (int i = 0; i < 2; i++) begin
      tick(); memOK = HLD; #2;
      checks++; if (memWR !== 1'b1 || memAddr !== dcAddr) begin errors++; $display("FAIL fault_kept%0d got wr=%0h addr=%0h exp wr=1 addr=%0h", i, memWR, memAddr, dcAddr); end
      checks++; if (icOK !== HLD) begin errors++; $display("FAIL fault_kept%0d_icOK got %0h exp %0h", i, icOK, HLD); end
    end
    tick(); dcWR = 0; memOK = RDY; #2;
    checks++; if (memWR !== 1'b0) begin errors++; $display("FAIL fault_release_memWR got %0h exp 0", memWR); end
    n = 0;
    while (n < 40) begin
      tick(); #2;
      if (memOE === 1'b1) break;
      n++;
    end
    checks++; if (n !== G + 1) begin errors++; $display("FAIL fault_dead_cycles got %0d exp %0d", n, G + 1); end
    modelLastD = 0;
    tick();
    idle_cycles(G + 3);
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      int mode, nBeats;
      bit wantI, wantD, dWrite, expD;
      logic [1:0] expStb, ownOK, othOK, othExp;
      logic [127:0] ownData, othData;
      mode = $urandom_range(0, 2);
      wantI = (mode != 1); wantD = (mode != 0); dWrite = 1'($urandom_range(0, 1));
      icAddr = $urandom; dcAddr = $urandom; icOp = 5'($urandom); dcOp = 5'($urandom);
      icOutData = rand128(); dcOutData = rand128();
      icOE = wantI; dcOE = wantD & ~dWrite; dcWR = wantD & dWrite; memOK = RDY;
      expD = wantD && (!wantI || tieWinnerD(modelLastD));
      expStb = expD ? {~dWrite, dWrite} : 2'b10;
      #2;
      checks++; if ({memOE, memWR} !== 2'b00) begin errors++; $display("FAIL rnd%0d_idle got %0h exp 0", t, {memOE, memWR}); end
      tick();
      nBeats = $urandom_range(1, 3);
      for (int b = 0; b < nBeats; b++) begin
        int lat;
        lat = $urandom_range(0, 2);
        for (int s = 0; s <= lat; s++) begin
          memOK = (s == lat) ? OKB : HLD; memData = rand128(); #2;
          ownOK = expD ? dcOK : icOK; othOK = expD ? icOK : dcOK;
          ownData = expD ? dcData : icData; othData = expD ? icData : dcData;
          othExp = (expD ? wantI : wantD) ? HLD : RDY;
          checks++; if (memAddr !== (expD ? dcAddr : icAddr)) begin errors++; $display("FAIL rnd%0d_memAddr got %0h exp %0h", t, memAddr, expD ? dcAddr : icAddr); end
          checks++; if ({memOE, memWR} !== expStb) begin errors++; $display("FAIL rnd%0d_strobes got %0h exp %0h", t, {memOE, memWR}, expStb); end
          checks++; if (memOp !== (expD ? dcOp : icOp)) begin errors++; $display("FAIL rnd%0d_memOp got %0h exp %0h", t, memOp, expD ? dcOp : icOp); end
          checks++; if (memOutData !== (expD ? dcOutData : icOutData)) begin errors++; $display("FAIL rnd%0d_memOutData got %0h", t, memOutData); end
          checks++; if (ownOK !== memOK || ownData !== memData) begin errors++; $display("FAIL rnd%0d_owner_resp got ok=%0h exp ok=%0h", t, ownOK, memOK); end
          checks++; if (othOK !== othExp || othData !== 128'h0) begin errors++; $display("FAIL rnd%0d_other_resp got ok=%0h exp ok=%0h", t, othOK, othExp); end
          tick();
        end
        if (expD) dcAddr = $urandom; else icAddr = $urandom;
      end
      icOE = 0; dcOE = 0; dcWR = 0; memOK = RDY; #2;
      checks++; if ({memOE, memWR} !== 2'b00) begin errors++; $display("FAIL rnd%0d_release got %0h exp 0", t, {memOE, memWR}); end
      modelLastD = expD;
      idle_cycles(G + 3);
    end
  endtask

  initial begin
    checks = 0; errors = 0; modelLastD = 1;
    reset = 1;
    icAddr = '0; icOE = 0; icWR = 0; icOp = '0; icOutData = '0;
    dcAddr = '0; dcOE = 0; dcWR = 0; dcOp = '0; dcOutData = '0;
    memData = '0; memOK = RDY;
    test_reset();
    test_single_i();
    test_dword_fill();
    test_reset_mid();
    test_tie();
    test_drain();
    test_fault();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
